// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: decoded operands and controls in, registered copy out.
// master = decode/hazard side, slave = the id_ex_reg pipeline register.
interface id_ex_reg_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [3:0]  id_alu_op;
  logic        id_alu_src;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_reg_write;
  logic        id_mem_to_reg;
  logic        id_branch;
  logic        flush;
  logic        mem_stall;

  logic        id_ex_valid;
  logic [31:0] id_ex_pc;
  logic [31:0] id_ex_rs1_data;
  logic [31:0] id_ex_rs2_data;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rs1;
  logic [4:0]  id_ex_rs2;
  logic [4:0]  id_ex_rd;
  logic        id_ex_uses_rs1;
  logic        id_ex_uses_rs2;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_alu_src;
  logic        id_ex_mem_read;
  logic        id_ex_mem_write;
  logic        id_ex_reg_write;
  logic        id_ex_mem_to_reg;
  logic        id_ex_branch;
  logic        load_use_stall;
  logic        pc_write_en;
  logic        if_id_write_en;
  logic [15:0] stall_count;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    output id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
    output id_alu_op, id_alu_src, id_mem_read, id_mem_write,
    output id_reg_write, id_mem_to_reg, id_branch,
    output flush, mem_stall,
    input  id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data,
    input  id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd,
    input  id_ex_uses_rs1, id_ex_uses_rs2, id_ex_alu_op,
    input  id_ex_alu_src, id_ex_mem_read, id_ex_mem_write,
    input  id_ex_reg_write, id_ex_mem_to_reg, id_ex_branch,
    input  load_use_stall, pc_write_en, if_id_write_en, stall_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    input  id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
    input  id_alu_op, id_alu_src, id_mem_read, id_mem_write,
    input  id_reg_write, id_mem_to_reg, id_branch,
    input  flush, mem_stall,
    output id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data,
    output id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd,
    output id_ex_uses_rs1, id_ex_uses_rs2, id_ex_alu_op,
    output id_ex_alu_src, id_ex_mem_read, id_ex_mem_write,
    output id_ex_reg_write, id_ex_mem_to_reg, id_ex_branch,
    output load_use_stall, pc_write_en, if_id_write_en, stall_count
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble counter.
// Ports: clk, rst (sync, active-high), bus (id_ex_reg_if.slave).
module id_ex_reg #(
  parameter logic [15:0] STALL_SAT = 16'hFFFF
) (
  input logic        clk,
  input logic        rst,
  id_ex_reg_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
  } ex_t;

  ex_t         r_ex;
  ex_t         w_cap;
  logic [15:0] r_stall_cnt;
  logic        w_load_use;
  logic        w_en;

  assign w_load_use = bus.id_valid & r_ex.valid & r_ex.mem_read
                    & (r_ex.rd != 5'd0)
                    & ((bus.id_uses_rs1 & (bus.id_rs1 == r_ex.rd))
                     | (bus.id_uses_rs2 & (bus.id_rs2 == r_ex.rd)));

  // A flush discards the dependent instruction, so it must not freeze fetch.
  assign w_en = !(bus.mem_stall | (w_load_use & !bus.flush));

  always_comb begin
    w_cap = '{
      valid:      bus.id_valid,
      pc:         bus.id_pc,
      rs1_data:   bus.id_rs1_data,
      rs2_data:   bus.id_rs2_data,
      imm:        bus.id_imm,
      rs1:        bus.id_rs1,
      rs2:        bus.id_rs2,
      rd:         bus.id_rd,
      uses_rs1:   bus.id_uses_rs1,
      uses_rs2:   bus.id_uses_rs2,
      alu_op:     bus.id_alu_op,
      alu_src:    bus.id_alu_src,
      mem_read:   bus.id_mem_read,
      mem_write:  bus.id_mem_write,
      reg_write:  bus.id_reg_write,
      mem_to_reg: bus.id_mem_to_reg,
      branch:     bus.id_branch
    };
    // Empty slots must never cause architectural side effects downstream.
    if (!bus.id_valid) begin
      w_cap.reg_write = 1'b0;
      w_cap.mem_read  = 1'b0;
      w_cap.mem_write = 1'b0;
      w_cap.branch    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex        <= '0;
      r_stall_cnt <= '0;
    end else if (bus.flush) begin
      r_ex <= '0;
    end else if (bus.mem_stall) begin
      r_ex <= r_ex;
    end else if (w_load_use) begin
      r_ex <= '0;
      if (r_stall_cnt < STALL_SAT)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end else begin
      r_ex <= w_cap;
    end
  end

  assign bus.id_ex_valid      = r_ex.valid;
  assign bus.id_ex_pc         = r_ex.pc;
  assign bus.id_ex_rs1_data   = r_ex.rs1_data;
  assign bus.id_ex_rs2_data   = r_ex.rs2_data;
  assign bus.id_ex_imm        = r_ex.imm;
  assign bus.id_ex_rs1        = r_ex.rs1;
  assign bus.id_ex_rs2        = r_ex.rs2;
  assign bus.id_ex_rd         = r_ex.rd;
  assign bus.id_ex_uses_rs1   = r_ex.uses_rs1;
  assign bus.id_ex_uses_rs2   = r_ex.uses_rs2;
  assign bus.id_ex_alu_op     = r_ex.alu_op;
  assign bus.id_ex_alu_src    = r_ex.alu_src;
  assign bus.id_ex_mem_read   = r_ex.mem_read;
  assign bus.id_ex_mem_write  = r_ex.mem_write;
  assign bus.id_ex_reg_write  = r_ex.reg_write;
  assign bus.id_ex_mem_to_reg = r_ex.mem_to_reg;
  assign bus.id_ex_branch     = r_ex.branch;
  assign bus.load_use_stall   = w_load_use;
  assign bus.pc_write_en      = w_en;
  assign bus.if_id_write_en   = w_en;
  assign bus.stall_count      = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios then random traffic.
// Expected values come from a transaction-level model of the ID/EX slot.
module tb_id_ex_reg;

  localparam logic [15:0] SAT = 16'd20;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
  } slot_t;

  logic  clk = 1'b0;
  logic  d_rst;
  logic  d_flush;
  logic  d_stall;
  slot_t d;
  slot_t obs;

  slot_t       m;
  logic [15:0] mcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_reg_if bus ();

  id_ex_reg #(.STALL_SAT(SAT)) dut (
    .clk (clk),
    .rst (d_rst),
    .bus (bus.slave)
  );

  assign bus.id_valid      = d.valid;
  assign bus.id_pc         = d.pc;
  assign bus.id_rs1_data   = d.rs1_data;
  assign bus.id_rs2_data   = d.rs2_data;
  assign bus.id_imm        = d.imm;
  assign bus.id_rs1        = d.rs1;
  assign bus.id_rs2        = d.rs2;
  assign bus.id_rd         = d.rd;
  assign bus.id_uses_rs1   = d.uses_rs1;
  assign bus.id_uses_rs2   = d.uses_rs2;
  assign bus.id_alu_op     = d.alu_op;
  assign bus.id_alu_src    = d.alu_src;
  assign bus.id_mem_read   = d.mem_read;
  assign bus.id_mem_write  = d.mem_write;
  assign bus.id_reg_write  = d.reg_write;
  assign bus.id_mem_to_reg = d.mem_to_reg;
  assign bus.id_branch     = d.branch;
  assign bus.flush         = d_flush;
  assign bus.mem_stall     = d_stall;

  assign obs = '{
    valid:      bus.id_ex_valid,
    pc:         bus.id_ex_pc,
    rs1_data:   bus.id_ex_rs1_data,
    rs2_data:   bus.id_ex_rs2_data,
    imm:        bus.id_ex_imm,
    rs1:        bus.id_ex_rs1,
    rs2:        bus.id_ex_rs2,
    rd:         bus.id_ex_rd,
    uses_rs1:   bus.id_ex_uses_rs1,
    uses_rs2:   bus.id_ex_uses_rs2,
    alu_op:     bus.id_ex_alu_op,
    alu_src:    bus.id_ex_alu_src,
    mem_read:   bus.id_ex_mem_read,
    mem_write:  bus.id_ex_mem_write,
    reg_write:  bus.id_ex_reg_write,
    mem_to_reg: bus.id_ex_mem_to_reg,
    branch:     bus.id_ex_branch
  };

  task automatic chk(string tag, logic [159:0] o, logic [159:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Does the load sitting in EX produce a register the ID instruction reads?
  function automatic bit dep(slot_t ex, slot_t id);
    bit hit;
    if (!(id.valid && ex.valid && ex.mem_read) || ex.rd == 5'd0)
      return 1'b0;
    hit = (id.uses_rs1 && id.rs1 == ex.rd)
       || (id.uses_rs2 && id.rs2 == ex.rd);
    return hit;
  endfunction

  // Inputs are set at the falling edge; step checks the combinational
  // outputs, advances the model, then checks the registered state.
  task automatic step();
    bit hz;
    bit en;
    slot_t cap;
    #1;
    hz = dep(m, d);
    en = !(d_stall || (hz && !d_flush));
    chk("load_use_stall", bus.load_use_stall, hz);
    chk("pc_write_en", bus.pc_write_en, en);
    chk("if_id_write_en", bus.if_id_write_en, en);
    cap = d;
    if (!d.valid) begin
      cap.reg_write = 0;
      cap.mem_read  = 0;
      cap.mem_write = 0;
      cap.branch    = 0;
    end
    if (d_rst) begin
      m    = '0;
      mcnt = 0;
    end else if (d_flush) begin
      m = '0;
    end else if (d_stall) begin
      m = m;
    end else if (hz) begin
      m = '0;
      if (mcnt < SAT) mcnt = mcnt + 1;
    end else begin
      m = cap;
    end
    @(posedge clk);
    #1;
    chk("id_ex_state", obs, m);
    chk("stall_count", bus.stall_count, mcnt);
    @(negedge clk);
  endtask

  function automatic slot_t rnd_slot();
    slot_t s;
    s.valid      = ($urandom_range(0, 9) < 8);
    s.pc         = $urandom;
    s.rs1_data   = $urandom;
    s.rs2_data   = $urandom;
    s.imm        = $urandom;
    s.rs1        = 5'($urandom_range(0, 3));
    s.rs2        = 5'($urandom_range(0, 3));
    s.rd         = 5'($urandom_range(0, 3));
    s.uses_rs1   = 1'($urandom);
    s.uses_rs2   = 1'($urandom);
    s.alu_op     = 4'($urandom);
    s.alu_src    = 1'($urandom);
    s.mem_read   = ($urandom_range(0, 9) < 4);
    s.mem_write  = 1'($urandom);
    s.reg_write  = 1'($urandom);
    s.mem_to_reg = 1'($urandom);
    s.branch     = 1'($urandom);
    return s;
  endfunction

  function automatic slot_t lw(logic [4:0] rd);
    slot_t s = '0;
    s.valid     = 1;
    s.pc        = 32'h200;
    s.rd        = rd;
    s.mem_read  = 1;
    s.reg_write = 1;
    return s;
  endfunction

  function automatic slot_t add(logic [4:0] rs1, logic u1, logic [4:0] rs2);
    slot_t s = '0;
    s.valid     = 1;
    s.pc        = 32'h204;
    s.rs1       = rs1;
    s.rs2       = rs2;
    s.uses_rs1  = u1;
    s.uses_rs2  = 1;
    s.rd        = 5'd9;
    s.reg_write = 1;
    return s;
  endfunction

  initial begin
    m       = rnd_slot();
    mcnt    = 16'hxxxx;
    d       = rnd_slot();
    d_flush = 1;
    d_stall = 1;
    d_rst   = 1;
    @(negedge clk);
    m    = '0;
    mcnt = 0;
    @(posedge clk);
    @(negedge clk);

    // reset holds bubble, enables follow !mem_stall
    d_flush = 0;
    d_stall = 0;
    step();
    chk("reset_valid", bus.id_ex_valid, 1'b0);
    chk("reset_count", bus.stall_count, 16'd0);
    d_rst = 0;

    // plain capture
    d = '0;
    d.valid     = 1;
    d.pc        = 32'h100;
    d.rd        = 5;
    d.reg_write = 1;
    step();
    chk("capture_pc", bus.id_ex_pc, 32'h100);
    chk("capture_rd", bus.id_ex_rd, 5'd5);
    chk("capture_valid", bus.id_ex_valid, 1'b1);

    // load-use: one bubble, then the dependent add is captured
    d = lw(7);
    step();
    d = add(7, 1, 3);
    #1;
    chk("lu_flag", bus.load_use_stall, 1'b1);
    chk("lu_pc_en", bus.pc_write_en, 1'b0);
    step();
    chk("lu_bubble", bus.id_ex_valid, 1'b0);
    chk("lu_count", bus.stall_count, 16'd1);
    step();
    chk("lu_capture", bus.id_ex_pc, 32'h204);

    // no false hazard: rd=0, or rs1 unused
    d = lw(0);
    step();
    d = add(0, 1, 0);
    step();
    chk("rd0_capture", bus.id_ex_valid, 1'b1);
    d = lw(7);
    step();
    d = add(7, 0, 2);
    step();
    chk("unused_capture", bus.id_ex_pc, 32'h204);

    // flush beats the hazard; flush beats mem_stall
    d = lw(7);
    step();
    d = add(7, 1, 3);
    d_flush = 1;
    #1;
    chk("flush_en", bus.pc_write_en, 1'b1);
    step();
    chk("flush_count", bus.stall_count, 16'd1);
    d = lw(6);
    d_flush = 0;
    step();
    d_flush = 1;
    d_stall = 1;
    step();
    chk("flush_stall", bus.id_ex_valid, 1'b0);
    d_flush = 0;
    d_stall = 0;

    // freeze three cycles with changing inputs
    d = lw(4);
    step();
    d_stall = 1;
    for (int i = 0; i < 3; i++) begin
      d = rnd_slot();
      step();
    end
    chk("freeze_pc", bus.id_ex_pc, 32'h200);
    d_stall = 0;

    // counter saturation, then reset in the middle of a stall
    for (int i = 0; i < int'(SAT) + 3; i++) begin
      d = lw(1);
      step();
      d = add(1, 1, 0);
      step();
    end
    chk("sat_count", bus.stall_count, SAT);
    d = lw(1);
    step();
    d = add(1, 1, 0);
    d_rst = 1;
    step();
    chk("rst_count", bus.stall_count, 16'd0);
    chk("rst_valid", bus.id_ex_valid, 1'b0);
    d_rst = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      d       = rnd_slot();
      d_flush = ($urandom_range(0, 99) < 8);
      d_stall = ($urandom_range(0, 99) < 15);
      d_rst   = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
